// File: rtl/processinho_pkg.sv
// Shared definitions for the processinho sequencer and its datapath:
// FSM state encoding, operand width and ULA opcodes.
package processinho_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StExec  = 3'd3,
        StWait  = 3'd4,
        StDone  = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OpAdd = 4'd0;
    localparam logic [OP_W-1:0] OpSub = 4'd1;
    localparam logic [OP_W-1:0] OpAnd = 4'd2;
    localparam logic [OP_W-1:0] OpOr  = 4'd3;
    localparam logic [OP_W-1:0] OpXor = 4'd4;

endpackage

// File: rtl/processinho_if.sv
// Request, board-control, ULA and datapath-strobe signals of the sequencer.
interface processinho_if;
    import processinho_pkg::*;

    logic            req;
    logic [OP_W-1:0] a_in;
    logic [OP_W-1:0] b_in;
    logic [OP_W-1:0] op_in;
    logic            step_mode;
    logic            step_btn;
    logic [7:0]      ula_result;

    logic            ack;
    logic            busy;
    logic            setRegA;
    logic            setRegB;
    logic [OP_W-1:0] operando;
    logic [OP_W-1:0] ula_operation;
    logic            latch_ula;
    logic [7:0]      result;
    logic            done;
    logic [2:0]      state;

    modport master (
        output req, a_in, b_in, op_in, step_mode, step_btn, ula_result,
        input  ack, busy, setRegA, setRegB, operando, ula_operation, latch_ula,
               result, done, state
    );

    modport slave (
        input  req, a_in, b_in, op_in, step_mode, step_btn, ula_result,
        output ack, busy, setRegA, setRegB, operando, ula_operation, latch_ula,
               result, done, state
    );

endinterface

// File: rtl/rise_edge.sv
// One-cycle pulse on each 0->1 transition of an already synchronised level.
module rise_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/processinho_sequencer.sv
// Sequences one processinho operation: load A, load B, execute, wait for the
// ULA, capture the result. Optional push-button stepping for demonstrations.
module processinho_sequencer
    import processinho_pkg::*;
#(
    parameter int unsigned ULA_LATENCY = 1
) (
    input logic           clock,
    input logic           reset,
    processinho_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d, op_q, op_d;
    logic [OP_W-1:0]   operando_q, operando_d, ula_op_q, ula_op_d;
    logic [7:0]        result_q, result_d;
    logic              ack_q, ack_d, set_a_q, set_a_d, set_b_q, set_b_d;
    logic              latch_q, latch_d, done_q, done_d;
    logic              step_pulse, advance;

    rise_edge u_step_edge (
        .clock (clock),
        .reset (reset),
        .level (bus.step_btn),
        .pulse (step_pulse)
    );

    assign advance = ~bus.step_mode | step_pulse;

    // Strobes are registered on the edge that leaves their phase, so each one
    // appears the cycle after its state (and after the button edge in step mode).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        operando_d = operando_q;
        ula_op_d   = ula_op_q;
        result_d   = result_q;
        ack_d      = 1'b0;
        set_a_d    = 1'b0;
        set_b_d    = 1'b0;
        latch_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.req) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    op_d    = bus.op_in;
                    ack_d   = 1'b1;
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                if (advance) begin
                    operando_d = a_q;
                    set_a_d    = 1'b1;
                    state_d    = StLoadB;
                end
            end
            StLoadB: begin
                if (advance) begin
                    operando_d = b_q;
                    set_b_d    = 1'b1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (advance) begin
                    ula_op_d = op_q;
                    latch_d  = 1'b1;
                    cnt_d    = CNT_W'(ULA_LATENCY);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // ula_result is valid ULA_LATENCY cycles after the latch_ula cycle.
                if (advance) begin
                    result_d = bus.ula_result;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            operando_q <= '0;
            ula_op_q   <= '0;
            result_q   <= '0;
            ack_q      <= 1'b0;
            set_a_q    <= 1'b0;
            set_b_q    <= 1'b0;
            latch_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            operando_q <= operando_d;
            ula_op_q   <= ula_op_d;
            result_q   <= result_d;
            ack_q      <= ack_d;
            set_a_q    <= set_a_d;
            set_b_q    <= set_b_d;
            latch_q    <= latch_d;
            done_q     <= done_d;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.setRegA       = set_a_q;
    assign bus.setRegB       = set_b_q;
    assign bus.operando      = operando_q;
    assign bus.ula_operation = ula_op_q;
    assign bus.latch_ula     = latch_q;
    assign bus.result        = result_q;
    assign bus.done          = done_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_processinho_sequencer.sv
// Scoreboard bench: stimulus queues expected strobes by cycle, a monitor pops
// and compares them whenever the DUT raises a strobe.
module tb_processinho_sequencer;
    import processinho_pkg::*;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    string names[5] = '{"ack", "setRegA", "setRegB", "latch_ula", "done"};

    localparam logic [3:0] VA[5] = '{4'd3, 4'd9, 4'd6, 4'd10, 4'd15};
    localparam logic [3:0] VB[5] = '{4'd5, 4'd4, 4'd13, 4'd5, 4'd6};
    localparam logic [3:0] VO[5] = '{OpAdd, OpSub, OpAnd, OpOr, OpXor};
    localparam logic [7:0] VE[5] = '{8'd8, 8'd5, 8'd4, 8'd15, 8'd9};

    processinho_if ifc1 ();
    processinho_if ifc4 ();

    processinho_sequencer #(.ULA_LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc1.slave)
    );

    processinho_sequencer #(.ULA_LATENCY(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc4.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
        case (op)
            OpAdd:   return {4'b0, a} + {4'b0, b};
            OpSub:   return {4'b0, a} - {4'b0, b};
            OpAnd:   return {4'b0, a & b};
            OpOr:    return {4'b0, a | b};
            OpXor:   return {4'b0, a ^ b};
            default: return 8'd0;
        endcase
    endfunction

    // External datapath for dut1: two registers and a ULA that holds its output.
    logic [3:0] reg_a = '0;
    logic [3:0] reg_b = '0;
    logic [7:0] ula1  = '0;
    always @(posedge clock) begin
        if (ifc1.setRegA) reg_a <= ifc1.operando;
        if (ifc1.setRegB) reg_b <= ifc1.operando;
        if (ifc1.latch_ula) ula1 <= alu(reg_a, reg_b, ifc1.ula_operation);
    end
    assign ifc1.ula_result = ula1;
    // dut4 sees a value that changes every cycle, so the capture cycle is visible.
    assign ifc4.ula_result = 8'(cyc) ^ 8'h5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_op(input int t, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [7:0] res);
        push(0, t, 8'd0);
        push(1, t + 1, {4'b0, a});
        push(2, t + 2, {4'b0, b});
        push(3, t + 3, {4'b0, op});
        push(4, t + 5, res);
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        ifc1.a_in  = a;
        ifc1.b_in  = b;
        ifc1.op_in = op;
        ifc1.req   = 1'b1;
    endtask

    // Called at a negedge with dut1 idle; the ack is due in the next cycle.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input logic [7:0] res);
        int t;
        t = cyc + 1;
        drive(a, b, op);
        push_op(t, a, b, op, res);
        @(negedge clock);
        ifc1.req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (ifc1.busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) check("idle_timeout", 32'(ifc1.busy), 32'd0);
    endtask

    always @(negedge clock) begin
        int         n;
        int         kind;
        logic [7:0] data;
        exp_t       e;
        if (!reset) begin
            n = int'(ifc1.ack) + int'(ifc1.setRegA) + int'(ifc1.setRegB)
              + int'(ifc1.latch_ula) + int'(ifc1.done);
            if (n > 1) check("strobe_exclusive", 32'(n), 32'd1);
            if (n > 0) begin
                kind = ifc1.ack ? 0 : ifc1.setRegA ? 1 : ifc1.setRegB ? 2 :
                       ifc1.latch_ula ? 3 : 4;
                case (kind)
                    1, 2:    data = {4'b0, ifc1.operando};
                    3:       data = {4'b0, ifc1.ula_operation};
                    4:       data = ifc1.result;
                    default: data = 8'd0;
                endcase
                if (exp_q.size() == 0) begin
                    check({"unexpected_", names[kind]}, 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check({names[e.kind], "_kind"}, 32'(kind), 32'(e.kind));
                    check({names[e.kind], "_cycle"}, 32'(cyc), 32'(e.cyc));
                    check({names[e.kind], "_data"}, 32'(data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p;
        logic [7:0] step_data[4];
        logic [7:0] exp4;

        ifc1.req = 0; ifc1.a_in = 0; ifc1.b_in = 0; ifc1.op_in = 0;
        ifc1.step_mode = 0; ifc1.step_btn = 0;
        ifc4.req = 0; ifc4.a_in = 0; ifc4.b_in = 0; ifc4.op_in = 0;
        ifc4.step_mode = 0; ifc4.step_btn = 0;

        #1 reset = 1'b1;
        @(negedge clock);
        check("reset_state", 32'(ifc1.state), 32'd0);
        check("reset_outputs", 32'({ifc1.ack, ifc1.busy, ifc1.setRegA, ifc1.setRegB,
              ifc1.latch_ula, ifc1.done, ifc1.operando, ifc1.ula_operation, ifc1.result}), 32'd0);
        check("reset_outputs_l4", 32'({ifc4.ack, ifc4.busy, ifc4.state, ifc4.result}), 32'd0);
        #2 reset = 1'b0;

        // Continuous mode, back-to-back directed vectors.
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            issue(VA[i], VB[i], VO[i], VE[i]);
        end

        // req held high: one ack per 6-cycle sequence, toggles while busy ignored.
        wait_idle();
        t0 = cyc + 1;
        drive(4'd7, 4'd2, OpAdd);
        push_op(t0, 4'd7, 4'd2, OpAdd, 8'd9);
        push_op(t0 + 6, 4'd7, 4'd2, OpAdd, 8'd9);
        push_op(t0 + 12, 4'd7, 4'd2, OpAdd, 8'd9);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clock);
            ifc1.req = (k inside {2, 3, 8, 9, 13}) ? 1'b0 : 1'b1;
        end

        // Step mode: presses 10 cycles apart, each held for 3 cycles.
        wait_idle();
        ifc1.step_mode = 1'b1;
        step_data = '{8'd11, 8'd3, {4'b0, OpSub}, 8'd8};
        t0 = cyc + 1;
        drive(4'd11, 4'd3, OpSub);
        push(0, t0, 8'd0);
        @(negedge clock);
        ifc1.req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = t0 + 4 + 10 * i;
            repeat (p - cyc) @(negedge clock);
            ifc1.step_btn = 1'b1;
            push(i + 1, p + 1, step_data[i]);
            repeat (3) @(negedge clock);
            ifc1.step_btn = 1'b0;
        end
        wait_idle();
        ifc1.step_mode = 1'b0;

        // Asynchronous reset while waiting on the ULA.
        wait_idle();
        t0 = cyc + 1;
        issue(4'd10, 4'd5, OpOr, 8'd15);
        repeat (3) @(negedge clock);
        #2;
        check("wait_state", 32'(ifc1.state), 32'(StWait));
        reset = 1'b1;
        #1;
        check("midop_reset_state", 32'(ifc1.state), 32'd0);
        check("midop_reset_strobes", 32'({ifc1.ack, ifc1.setRegA, ifc1.setRegB,
              ifc1.latch_ula, ifc1.done, ifc1.busy}), 32'd0);
        check("midop_reset_result", 32'(ifc1.result), 32'd0);
        check("midop_reset_operando", 32'(ifc1.operando), 32'd0);
        check("midop_reset_ula_operation", 32'(ifc1.ula_operation), 32'd0);
        exp_q.delete();
        @(negedge clock);
        #2 reset = 1'b0;
        wait_idle();
        issue(4'd2, 4'd2, OpAdd, 8'd4);

        // Illegal state code recovers to IDLE without strobes.
        wait_idle();
        force dut1.state_q = state_t'(3'd6);
        #1 release dut1.state_q;
        @(posedge clock);
        #1;
        check("bad_state_recover", 32'(ifc1.state), 32'd0);
        check("bad_state_strobes", 32'({ifc1.ack, ifc1.setRegA, ifc1.setRegB,
              ifc1.latch_ula, ifc1.done}), 32'd0);

        // ULA_LATENCY = 4 instance: done at t+8, result sampled during t+7.
        @(negedge clock);
        ifc4.a_in = 4'd1; ifc4.b_in = 4'd2; ifc4.op_in = OpAdd;
        ifc4.req = 1'b1;
        t0 = cyc + 1;
        exp4 = 8'(t0 + 7) ^ 8'h5A;
        @(negedge clock);
        check("l4_ack", 32'(ifc4.ack), 32'd1);
        ifc4.req = 1'b0;
        repeat (7) @(negedge clock);
        check("l4_done_early", 32'(ifc4.done), 32'd0);
        @(negedge clock);
        check("l4_done", 32'(ifc4.done), 32'd1);
        check("l4_result", 32'(ifc4.result), 32'(exp4));

        repeat (4) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processinho_sequencer.md
# processinho_sequencer

Control FSM that sequences the processinho datapath (two 4-bit general registers feeding the ULA) for one operation at a time. It accepts a request `{a, b, op}` over a req/ack handshake, drives `setRegA`, `setRegB`, `operando`, `ula_operation` and `latch_ula` in order, waits the ULA latency, then captures the 8-bit ULA result and pulses `done`. An optional step mode lets a board push-button advance the sequence one phase at a time for demonstration.

## Interface
- `ULA_LATENCY`, default 1: cycles from the `latch_ula` cycle until `ula_result` is valid. Legal range is 1..15.
- `OP_W`, default 4: width of the operand and of the opcode.
- Reset is asynchronous and active-high.
- `clock`, input, 1: the single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `req`, input, 1: request for one operation. Held high until `ack`.
- `a_in`, input, `OP_W`: operand for register A.
- `b_in`, input, `OP_W`: operand for register B.
- `op_in`, input, `OP_W`: ULA opcode.
- `step_mode`, input, 1: 1 means phases advance only on a `step_btn` rising edge.
- `step_btn`, input, 1: raw button level, already synchronised.
- `ula_result`, input, 8: result from the ULA.
- `ack`, output, 1: one-cycle pulse when the request is accepted.
- `busy`, output, 1: high in every state except IDLE.
- `setRegA`, output, 1: one-cycle load strobe for register A.
- `setRegB`, output, 1: one-cycle load strobe for register B.
- `operando`, output, `OP_W`: operand bus shared by both registers.
- `ula_operation`, output, `OP_W`: opcode presented to the ULA.
- `latch_ula`, output, 1: one-cycle ULA execute strobe.
- `result`, output, 8: captured ULA result, held until the next capture.
- `done`, output, 1: one-cycle pulse; `result` is valid from this cycle.
- `state`, output, 3: current FSM state, for debug LEDs.

## Operation
- States: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, WAIT=4, DONE=5. Codes 6 and 7 are unused and go to IDLE on the next edge.
- **IDLE.** If `req`=1, capture `a_in`, `b_in` and `op_in` into `a_q`, `b_q` and `op_q`, pulse `ack`, and go to LOAD_A.
- **LOAD_A.** `operando`=`a_q`, `setRegA`=1. Then go to LOAD_B.
- **LOAD_B.** `operando`=`b_q`, `setRegB`=1. Then go to EXEC.
- **EXEC.** `ula_operation`=`op_q`, `latch_ula`=1. Load `cnt`=`ULA_LATENCY`, then go to WAIT.
- **WAIT.** Decrement `cnt` each cycle. In the cycle where `cnt`=1, capture `result`<=`ula_result` and go to DONE.
- **DONE.** `done`=1, then go to IDLE.
- `ula_operation` holds `op_q` from EXEC until the next accept, because the ULA may be combinational.
- `operando` holds its last driven value and is never tristated.
- **Step mode.**
  - With `step_mode`=1, each transition out of LOAD_A, LOAD_B, EXEC and DONE waits for a `step_btn` rising edge.
  - The strobe (`setRegA`, `setRegB`, `latch_ula` or `done`) asserts only in the cycle the edge is seen. Outside that cycle the strobe stays 0.
  - WAIT is never gated by `step_btn`.
  - IDLE acceptance is never gated by `step_btn`.
- **Boundaries.**
  - `req` while `busy`: ignored, no `ack`. The requester keeps `req` high.
  - `req` in the DONE cycle: accepted on the following cycle, in IDLE.
  - `step_mode` changing mid-sequence: takes effect from the next state decision.
  - `reset` mid-operation: immediately go to IDLE. All outputs go to 0, including `result`, `operando` and `ula_operation`. Any half-loaded registers are not repaired.

## Timing
- Reset values: every output is 0 and `state`=IDLE.
- Continuous mode, with the accept edge at cycle t:
  - `ack` high in t.
  - `setRegA` high in t+1.
  - `setRegB` high in t+2.
  - `latch_ula` high in t+3.
  - WAIT occupies t+4 .. t+3+`ULA_LATENCY`.
  - `done` high in t+4+`ULA_LATENCY`.
  - `result` is updated at that same edge.
- Fastest back-to-back rate: one operation every 5+`ULA_LATENCY` cycles.
- All strobes are mutually exclusive.
- All outputs are registered, except `busy`, which decodes `state`.

## Structure
- Package `processinho_pkg` holds:
  - the state enum/localparams (IDLE..DONE, 3-bit);
  - `OP_W`;
  - the ULA opcode constants shared with the ULA.
- Sub-module `rise_edge`: a 1-bit register plus an AND gate that produces a one-cycle pulse on each `step_btn` 0→1 transition. It resets to 0 asynchronously.
- Counter and FSM stay in the top of the block. The datapath registers and the ULA remain external.

## Test plan
- Continuous mode, `ULA_LATENCY`=1, request a=3, b=5, op=ADD, and the ULA model returns 8 one cycle after `latch_ula`. Required: `ack` at t, `setRegA` at t+1 with `operando`=3, `setRegB` at t+2 with `operando`=5, `latch_ula` at t+3, `done` at t+5, `result`=8.
- `ULA_LATENCY`=4: required `done` at t+8, and `result` equals the ULA value present at t+7.
- Hold `req` high continuously. Required: `ack` only in IDLE cycles, exactly one per 6-cycle sequence, and `req` toggling during `busy` has no effect.
- Step mode with pulses spaced 10 cycles apart. Required: each strobe fires exactly once, one cycle after each detected rising edge, and holding `step_btn` high produces no repeat strobe.
- Assert `reset` asynchronously during WAIT. Required: `state`=0, and `result`, `operando`, `ula_operation` and all strobes are 0 before the next clock edge; a new `req` is then accepted normally.
- Force `state` to 6. Required: IDLE on the next edge, with no strobes asserted.
